ifu_fetch_queue: RTL

Parametrised instruction fetch unit. It issues pipelined, in-order requests to instruction memory and buffers the returned instructions in a FQ_DEPTH-entry fetch queue. It presents {pc, inst, pc_next} to the IDU over a valid/ready handshake. It sits between the EXU redirect path and the IDU, and replaces the single-PC, one-at-a-time fetch stage.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_fq_mem.sv | 85 ++++++++
 rtl/ifu_fetch_queue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_e : fetch FSM states
//   fq_entry_t  : fetch queue entry view {pc, inst} at the default 32-bit widths
//   ADDR_INIT   : default fetch PC after reset
//   INST_BYTES  : PC increment per fetched instruction
package ifu_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  localparam logic [31:0] ADDR_INIT  = 32'h8000_0000;
  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/ifu_fq_mem.sv
// ifu_fq_mem: fetch queue storage with head/fill/tail pointers.
// Entries are allocated at tail (pc known at request time), filled in order
// at fill (inst arrives later), and popped at head.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_flush                   drop all entries (pointers -> 0), overrides all else
//   i_alloc, i_alloc_pc       allocate entry at tail with its pc
//   i_fill, i_fill_inst       write inst into oldest allocated unfilled entry
//   i_pop                     release head entry
//   o_full                    tail - head == FQ_DEPTH
//   o_filled                  head entry holds an instruction (head != fill)
//   o_pending                 allocated entries awaiting data (tail - fill)
//   o_head_pc, o_head_inst    head entry contents
module ifu_fq_mem
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned FQ_DEPTH   = 4,
  localparam int unsigned PW        = $clog2(FQ_DEPTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_alloc,
  input  logic [ADDR_WIDTH-1:0] i_alloc_pc,
  input  logic                  i_fill,
  input  logic [INST_WIDTH-1:0] i_fill_inst,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_filled,
  output logic [PW-1:0]         o_pending,
  output logic [ADDR_WIDTH-1:0] o_head_pc,
  output logic [INST_WIDTH-1:0] o_head_inst
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [ADDR_WIDTH-1:0] pc_q   [FQ_DEPTH];
  logic [INST_WIDTH-1:0] inst_q [FQ_DEPTH];

  always_comb begin
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    if (i_flush) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
    end else begin
      if (i_alloc) tail_d = tail_q + 1'b1;
      if (i_fill)  fill_d = fill_q + 1'b1;
      if (i_pop)   head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      if (!i_flush) begin
        if (i_alloc) pc_q[tail_q[PW-2:0]]   <= i_alloc_pc;
        if (i_fill)  inst_q[fill_q[PW-2:0]] <= i_fill_inst;
      end
    end
  end

  assign o_full      = (tail_q - head_q) == PW'(FQ_DEPTH);
  assign o_filled    = head_q != fill_q;
  assign o_pending   = tail_q - fill_q;
  assign o_head_pc   = pc_q[head_q[PW-2:0]];
  assign o_head_inst = inst_q[head_q[PW-2:0]];

endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: pipelined in-order instruction fetch with an FQ_DEPTH-entry
// fetch queue feeding the IDU over valid/ready.
// Ports:
//   i_sys_clk, i_sys_rst_n           clock, async active-low reset
//   i_fetch_en                       allow issuing new requests
//   i_exu_jmp_en, i_exu_jmp_pc       one-cycle redirect strobe and target
//   o_imem_req_valid/_addr, i_imem_req_ready   imem request channel
//   i_imem_rsp_valid/_inst           imem response (in order, no back-pressure)
//   o_ifu_valid, i_idu_ready         IDU handshake
//   o_ifu_pc/_inst/_pc_next          head entry contents
// Optional macro IFU_PERF_EN adds saturating counters:
//   o_perf_fetch_cnt (IDU pops), o_perf_flush_cnt (redirects),
//   o_perf_drop_cnt (discarded responses).
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            INST_WIDTH = 32,
  parameter int unsigned            FQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(ADDR_INIT)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_fetch_en,
  input  logic                  i_exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc,
  output logic                  o_imem_req_valid,
  input  logic                  i_imem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_imem_req_addr,
  input  logic                  i_imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] i_imem_rsp_inst,
  output logic                  o_ifu_valid,
  input  logic                  i_idu_ready,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc,
  output logic [INST_WIDTH-1:0] o_ifu_inst,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc_next
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]           o_perf_fetch_cnt,
  output logic [31:0]           o_perf_flush_cnt,
  output logic [31:0]           o_perf_drop_cnt
`endif
);

  localparam int unsigned PW = $clog2(FQ_DEPTH) + 1;
  // Repeated redirects while memory stalls can stack drops beyond one queue's
  // worth, so the drop counter is sized generously rather than to FQ_DEPTH.
  localparam int unsigned DROP_W = 16;

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic          fq_full;
  logic          fq_filled;
  logic [PW-1:0] fq_pending;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_keep;
  logic          pop;

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_fetch_en)  state_d = S_RUN;
      S_RUN: begin
        if (!i_fetch_en) state_d = S_IDLE;
        req_valid = !fq_full && !i_exu_jmp_en;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_fire = req_valid && i_imem_req_ready;
  assign rsp_keep = i_imem_rsp_valid && !i_exu_jmp_en && (drop_cnt_q == '0);
  assign pop      = fq_filled && i_idu_ready && !i_exu_jmp_en;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (i_exu_jmp_en) begin
      fetch_pc_d = i_exu_jmp_pc;
      // Every allocated-but-unfilled entry still has a response coming;
      // one arriving right now is consumed here instead of later.
      drop_cnt_d = drop_cnt_q + DROP_W'(fq_pending) - DROP_W'(i_imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INST_BYTES);
      if (i_imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ifu_fq_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .FQ_DEPTH   (FQ_DEPTH)
  ) u_fq_mem (
    .i_clk       (i_sys_clk),
    .i_rst_n     (i_sys_rst_n),
    .i_flush     (i_exu_jmp_en),
    .i_alloc     (req_fire),
    .i_alloc_pc  (fetch_pc_q),
    .i_fill      (rsp_keep),
    .i_fill_inst (i_imem_rsp_inst),
    .i_pop       (pop),
    .o_full      (fq_full),
    .o_filled    (fq_filled),
    .o_pending   (fq_pending),
    .o_head_pc   (o_ifu_pc),
    .o_head_inst (o_ifu_inst)
  );

  assign o_imem_req_valid = req_valid;
  assign o_imem_req_addr  = fetch_pc_q;
  assign o_ifu_valid      = fq_filled;
  assign o_ifu_pc_next    = o_ifu_pc + ADDR_WIDTH'(INST_BYTES);

`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_drop_q;
  logic        rsp_drop;

  assign rsp_drop = i_imem_rsp_valid && !rsp_keep;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (pop && (perf_fetch_q != '1))          perf_fetch_q <= perf_fetch_q + 1'b1;
      if (i_exu_jmp_en && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 1'b1;
      if (rsp_drop && (perf_drop_q != '1))      perf_drop_q  <= perf_drop_q + 1'b1;
    end
  end

  assign o_perf_fetch_cnt = perf_fetch_q;
  assign o_perf_flush_cnt = perf_flush_q;
  assign o_perf_drop_cnt  = perf_drop_q;
`endif

endmodule
